mandel_point_sequencer: RTL and testbench

//   Initiator side of the escape-time iteration core: walks a WIDTH x HEIGHT pixel grid over
//   the complex plane and, for each pixel, drives c = (re, im) plus the load strobe into the core.

---
 rtl/mandel_pkg.sv | 21 ++
 rtl/mandel_coord_stepper.sv | 92 +++++++++
 rtl/mandel_point_sequencer.sv | 139 +++++++++++++
 tb/tb_mandel_point_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types and constants for the escape-time sequencer and the iteration core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mandel_pkg;

    localparam int FX_W   = 32;
    localparam int FRAC_W = 21;

    // |z|^2 escape threshold of 4.0 in Q11.21
    localparam logic [FX_W-1:0] ESCAPE_THRESH = 32'h0080_0000;

    typedef logic signed [FX_W-1:0] fx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

endpackage

// File: rtl/mandel_coord_stepper.sv
// Pixel-grid walker: holds col/row and c = (c_re, c_im), advancing one pixel per adv strobe.
// Latency: new coordinate visible the cycle after init/adv.
// Backpressure: none; the owning FSM only strobes adv after the current pixel is handed off.
// Ports: init latches origin/step/extent and zeroes col/row; adv steps raster order;
//        last_pixel flags the bottom-right pixel of the latched grid.
module mandel_coord_stepper #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic               adv,
    input  logic [DATA_W-1:0]  x_min,
    input  logic [DATA_W-1:0]  y_max,
    input  logic [DATA_W-1:0]  step,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic [DATA_W-1:0]  c_re,
    output logic [DATA_W-1:0]  c_im,
    output logic               last_pixel
);

    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic [COORD_W-1:0] col_last_q, col_last_d, row_last_q, row_last_d;
    logic [DATA_W-1:0]  c_re_q, c_re_d, c_im_q, c_im_d;
    logic [DATA_W-1:0]  x_min_q, x_min_d, step_q, step_d;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        col_last_d = col_last_q;
        row_last_d = row_last_q;
        c_re_d     = c_re_q;
        c_im_d     = c_im_q;
        x_min_d    = x_min_q;
        step_d     = step_q;
        if (init) begin
            col_d      = '0;
            row_d      = '0;
            c_re_d     = x_min;
            c_im_d     = y_max;
            x_min_d    = x_min;
            step_d     = step;
            // Store the last index rather than the extent; a zero extent behaves as one.
            col_last_d = (width  == '0) ? '0 : width  - 1'b1;
            row_last_d = (height == '0) ? '0 : height - 1'b1;
        end else if (adv) begin
            if (col_q != col_last_q) begin
                col_d  = col_q + 1'b1;
                c_re_d = c_re_q + step_q;
            end else begin
                // Row wrap: re(c) restarts at the left edge, im(c) moves down one step.
                col_d  = '0;
                row_d  = row_q + 1'b1;
                c_re_d = x_min_q;
                c_im_d = c_im_q - step_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            col_last_q <= '0;
            row_last_q <= '0;
            c_re_q     <= '0;
            c_im_q     <= '0;
            x_min_q    <= '0;
            step_q     <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            col_last_q <= col_last_d;
            row_last_q <= row_last_d;
            c_re_q     <= c_re_d;
            c_im_q     <= c_im_d;
            x_min_q    <= x_min_d;
            step_q     <= step_d;
        end
    end

    assign col        = col_q;
    assign row        = row_q;
    assign c_re       = c_re_q;
    assign c_im       = c_im_q;
    assign last_pixel = (col_q == col_last_q) && (row_q == row_last_q);

endmodule

// File: rtl/mandel_point_sequencer.sv
// Escape-time initiator: loads c into the core per pixel, counts iterations, emits one result per pixel.
// Latency: 3 cycles per pixel minimum (LOAD, one ITER, EMIT), max_iter+2 maximum, plus stall time.
// Backpressure: result held in EMIT until pix_ready; no new pixel is loaded while stalled.
// Ports: start/x_min/y_max/step/width/height/max_iter configure a frame; core_a/b/ld/div talk
//        to the iteration core; pix_* is the result stream; busy/done report frame progress.
module mandel_point_sequencer
    import mandel_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 10,
    parameter int ITER_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  x_min,
    input  logic [DATA_W-1:0]  y_max,
    input  logic [DATA_W-1:0]  step,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic [ITER_W-1:0]  max_iter,
    output logic [DATA_W-1:0]  core_a,
    output logic [DATA_W-1:0]  core_b,
    output logic               core_ld,
    input  logic               core_div,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [ITER_W-1:0]  pix_iter,
    output logic               pix_escaped,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [ITER_W-1:0]  iter_cnt_q, iter_cnt_d;
    logic [ITER_W-1:0]  iter_last_q, iter_last_d;
    logic [ITER_W-1:0]  pix_iter_q, pix_iter_d;
    logic               pix_escaped_q, pix_escaped_d;
    logic               done_q, done_d;
    logic               init, adv, last_pixel;

    always_comb begin
        state_d       = state_q;
        iter_cnt_d    = iter_cnt_q;
        iter_last_d   = iter_last_q;
        pix_iter_d    = pix_iter_q;
        pix_escaped_d = pix_escaped_q;
        done_d        = 1'b0;
        init          = 1'b0;
        adv           = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    init        = 1'b1;
                    iter_last_d = (max_iter == '0) ? '0 : max_iter - 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                iter_cnt_d = '0;
                state_d    = ST_ITER;
            end
            ST_ITER: begin
                // Divergence is checked first so it wins over the cap in the same cycle.
                if (core_div) begin
                    pix_escaped_d = 1'b1;
                    pix_iter_d    = iter_cnt_q + 1'b1;
                    state_d       = ST_EMIT;
                end else if (iter_cnt_q == iter_last_q) begin
                    pix_escaped_d = 1'b0;
                    pix_iter_d    = iter_cnt_q + 1'b1;
                    state_d       = ST_EMIT;
                end else begin
                    iter_cnt_d = iter_cnt_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (pix_ready) begin
                    if (last_pixel) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        adv     = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            iter_cnt_q    <= '0;
            iter_last_q   <= '0;
            pix_iter_q    <= '0;
            pix_escaped_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            iter_cnt_q    <= iter_cnt_d;
            iter_last_q   <= iter_last_d;
            pix_iter_q    <= pix_iter_d;
            pix_escaped_q <= pix_escaped_d;
            done_q        <= done_d;
        end
    end

    mandel_coord_stepper #(
        .DATA_W  (DATA_W),
        .COORD_W (COORD_W)
    ) u_stepper (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .adv        (adv),
        .x_min      (x_min),
        .y_max      (y_max),
        .step       (step),
        .width      (width),
        .height     (height),
        .col        (pix_x),
        .row        (pix_y),
        .c_re       (core_a),
        .c_im       (core_b),
        .last_pixel (last_pixel)
    );

    assign core_ld     = (state_q == ST_LOAD);
    assign pix_valid   = (state_q == ST_EMIT);
    assign busy        = (state_q != ST_IDLE);
    assign pix_iter    = pix_iter_q;
    assign pix_escaped = pix_escaped_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mandel_point_sequencer.sv
// Scenario bench for mandel_point_sequencer: scoreboard of expected coordinates and pixel results.
// Latency: n/a.
// Backpressure: pix_ready driven per scenario.
module tb_mandel_point_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] x_min, y_max, step;
    logic [9:0]  width, height;
    logic [7:0]  max_iter;
    logic [31:0] core_a, core_b;
    logic        core_ld;
    logic        core_div = 1'b0;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  pix_iter;
    logic        pix_escaped;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] iter;
        logic       esc;
    } pix_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } crd_t;

    pix_t exp_pix[$];
    crd_t exp_crd[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   div_at   = 0;
    int   iter_cyc = 0;

    always #5 clk = ~clk;

    mandel_point_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .x_min       (x_min),
        .y_max       (y_max),
        .step        (step),
        .width       (width),
        .height      (height),
        .max_iter    (max_iter),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_ld     (core_ld),
        .core_div    (core_div),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_iter    (pix_iter),
        .pix_escaped (pix_escaped),
        .busy        (busy),
        .done        (done)
    );

    // Core model + scoreboard: raises core_div on the div_at-th ITER cycle of each pixel,
    // checks c at every load and every accepted result against the queued expectations.
    always @(negedge clk) begin
        crd_t ec;
        pix_t ep;
        #1;
        if (!rst_n) begin
            iter_cyc = 0;
            core_div = 1'b0;
        end else begin
            if (core_ld) begin
                iter_cyc = 0;
                n_checks++;
                if (exp_crd.size() == 0) begin
                    $display("FAIL coord_unexpected got a=%h b=%h, expected no load", core_a, core_b);
                end else begin
                    ec = exp_crd.pop_front();
                    if ({core_a, core_b} !== {ec.a, ec.b})
                        $display("FAIL coord got a=%h b=%h expected a=%h b=%h", core_a, core_b, ec.a, ec.b);
                    else
                        n_pass++;
                end
            end else if (busy && !pix_valid) begin
                iter_cyc++;
            end
            core_div = (div_at != 0) && busy && !core_ld && !pix_valid && (iter_cyc == div_at);
            if (pix_valid && pix_ready) begin
                n_checks++;
                if (exp_pix.size() == 0) begin
                    $display("FAIL pixel_unexpected got x=%0d y=%0d iter=%0d esc=%0d", pix_x, pix_y, pix_iter, pix_escaped);
                end else begin
                    ep = exp_pix.pop_front();
                    if ({pix_x, pix_y, pix_iter, pix_escaped} !== ep)
                        $display("FAIL pixel got x=%0d y=%0d iter=%0d esc=%0d expected x=%0d y=%0d iter=%0d esc=%0d",
                                 pix_x, pix_y, pix_iter, pix_escaped, ep.x, ep.y, ep.iter, ep.esc);
                    else
                        n_pass++;
                end
            end
        end
    end

    // Drives one start pulse and queues the expected raster of coordinates and results.
    task automatic start_frame(input logic [31:0] xm, input logic [31:0] ym, input logic [31:0] st,
                               input logic [9:0] w, input logic [9:0] h, input logic [7:0] m, input int d);
        int          we, he, me;
        logic        esc;
        logic [7:0]  it;
        logic [31:0] cc, rr;
        we  = (w == 0) ? 1 : int'(w);
        he  = (h == 0) ? 1 : int'(h);
        me  = (m == 0) ? 1 : int'(m);
        esc = (d != 0) && (d <= me);
        it  = esc ? 8'(d) : 8'(me);
        for (int r = 0; r < he; r++) begin
            for (int c = 0; c < we; c++) begin
                cc = c;
                rr = r;
                exp_crd.push_back('{a: xm + cc * st, b: ym - rr * st});
                exp_pix.push_back('{x: 10'(c), y: 10'(r), iter: it, esc: esc});
            end
        end
        x_min    = xm;
        y_max    = ym;
        step     = st;
        width    = w;
        height   = h;
        max_iter = m;
        div_at   = d;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({core_a, core_b, core_ld, pix_valid, pix_x, pix_y, pix_iter, pix_escaped, busy, done} !== '0)
            $display("FAIL reset_outputs got busy=%0d valid=%0d ld=%0d a=%h, expected all zero", busy, pix_valid, core_ld, core_a);
        else
            n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit got;
        start_frame(32'h0, 32'h0, 32'h0010_0000, 10'd2, 10'd2, 8'd4, 0);
        wait_done(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL basic_done got timeout expected done pulse"); else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) $display("FAIL basic_pulse got done=%0d busy=%0d expected 0 0", done, busy);
        else n_pass++;
        n_checks++;
        if (exp_pix.size() + exp_crd.size() != 0)
            $display("FAIL basic_drain got %0d pending expected 0", exp_pix.size() + exp_crd.size());
        else n_pass++;
    endtask

    task automatic test_coords;
        bit got;
        start_frame(32'hFFC0_0000, 32'h0020_0000, 32'h0010_0000, 10'd2, 10'd2, 8'd2, 0);
        wait_done(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL coords_done got timeout expected done pulse"); else n_pass++;
    endtask

    task automatic test_escape;
        bit got;
        start_frame(32'h0, 32'h0, 32'h0, 10'd1, 10'd1, 8'd8, 3);
        wait_done(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL escape_done got timeout expected done pulse"); else n_pass++;
    endtask

    task automatic test_race;
        bit got;
        start_frame(32'h0, 32'h0, 32'h0, 10'd1, 10'd1, 8'd5, 5);
        wait_done(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL race_done got timeout expected done pulse"); else n_pass++;
        n_checks++;
        if ({pix_iter, pix_escaped} !== {8'd5, 1'b1})
            $display("FAIL race_result got iter=%0d esc=%0d expected iter=5 esc=1", pix_iter, pix_escaped);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        bit   got;
        logic [28:0] snap;
        pix_ready = 1'b0;
        start_frame(32'h0000_1000, 32'h0, 32'h0000_0100, 10'd2, 10'd1, 8'd2, 1);
        got = 1'b0;
        for (int cyc = 0; cyc < 50 && !got; cyc++) begin
            if (pix_valid) got = 1'b1; else @(negedge clk);
        end
        n_checks++;
        if (got !== 1'b1) $display("FAIL stall_valid got timeout expected pix_valid"); else n_pass++;
        snap = {pix_x, pix_y, pix_iter, pix_escaped};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({pix_valid, core_ld, pix_x, pix_y, pix_iter, pix_escaped} !== {1'b1, 1'b0, snap})
                $display("FAIL stall_hold cycle %0d got valid=%0d ld=%0d payload=%h expected valid=1 ld=0 payload=%h",
                         i, pix_valid, core_ld, {pix_x, pix_y, pix_iter, pix_escaped}, snap);
            else n_pass++;
        end
        pix_ready = 1'b1;
        wait_done(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL stall_done got timeout expected done pulse"); else n_pass++;
    endtask

    task automatic test_zero_cfg;
        bit got;
        start_frame(32'h0000_0040, 32'h0000_0080, 32'h1, 10'd0, 10'd0, 8'd0, 0);
        wait_done(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL zero_done got timeout expected done pulse"); else n_pass++;
        n_checks++;
        if (exp_pix.size() != 0) $display("FAIL zero_drain got %0d pending expected 0", exp_pix.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit got;
        start_frame(32'h0, 32'h0, 32'h0, 10'd1, 10'd1, 8'd2, 0);
        wait_done(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL b2b_first got timeout expected done pulse"); else n_pass++;
        // Start is raised in the very cycle done pulses.
        start_frame(32'h0000_0300, 32'h0000_0500, 32'h0000_0010, 10'd3, 10'd1, 8'd1, 0);
        wait_done(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL b2b_second got timeout expected done pulse"); else n_pass++;
        n_checks++;
        if (exp_pix.size() + exp_crd.size() != 0)
            $display("FAIL b2b_drain got %0d pending expected 0", exp_pix.size() + exp_crd.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit got;
        bit saw_done;
        start_frame(32'h0, 32'h0, 32'h0000_0100, 10'd4, 10'd4, 8'd200, 0);
        repeat (10) @(negedge clk);
        n_checks++;
        if ({busy, core_ld, pix_valid} !== 3'b100)
            $display("FAIL midrst_iter got busy=%0d ld=%0d valid=%0d expected 1 0 0", busy, core_ld, pix_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({core_a, core_b, core_ld, pix_valid, pix_x, pix_y, pix_iter, pix_escaped, busy, done} !== '0)
            $display("FAIL midrst_outputs got busy=%0d a=%h b=%h expected all zero", busy, core_a, core_b);
        else n_pass++;
        exp_pix.delete();
        exp_crd.delete();
        div_at   = 0;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done) saw_done = 1'b1;
        n_checks++;
        if (saw_done !== 1'b0) $display("FAIL midrst_nodone got done=1 expected 0"); else n_pass++;
        start_frame(32'h0000_0200, 32'h0000_0400, 32'h0000_0020, 10'd2, 10'd2, 8'd3, 0);
        wait_done(got);
        n_checks++;
        if (got !== 1'b1) $display("FAIL midrst_frame got timeout expected done pulse"); else n_pass++;
        n_checks++;
        if (exp_pix.size() + exp_crd.size() != 0)
            $display("FAIL midrst_drain got %0d pending expected 0", exp_pix.size() + exp_crd.size());
        else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b1;
        x_min     = '0;
        y_max     = '0;
        step      = '0;
        width     = '0;
        height    = '0;
        max_iter  = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_coords();
        test_escape();
        test_race();
        test_backpressure();
        test_zero_cfg();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
